// File: rtl/rv32i_defs.sv
// rtl/rv32i_defs.sv - shared widths and port IDs for the RV32I memory path
package rv32i_defs;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;
endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// rtl/rv32i_mem_arbiter_if.sv - one requester's request/response bundle
import rv32i_defs::*;

interface rv32i_mem_arbiter_if #(
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/rv32i_mem_arbiter_rr_arb2.sv
// rtl/rv32i_mem_arbiter_rr_arb2.sv - two-input round-robin grant, pointer moves on accept
import rv32i_defs::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant;

    // Contention goes to whichever port did not win last time.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == PORT_LS) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT_LS;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - fetch/LSU sharing of one single-ported synchronous RAM
import rv32i_defs::*;

module rv32i_mem_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    rv32i_mem_arbiter_if.slave port0,
    rv32i_mem_arbiter_if.slave port1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [1:0] req;
    logic [1:0] grant;
    logic       accept;
    logic       sel;
    logic       rsp_pend;
    logic       rsp_sel;
    logic       rsp_wr;
    logic       unused_addr_bits;

    assign req    = {port1.req_valid, port0.req_valid};
    assign accept = |(req & grant);
    assign sel    = grant[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    assign port0.req_ready = grant[0];
    assign port1.req_ready = grant[1];

    assign mem_en    = |grant;
    assign mem_we    = mem_en & (sel ? port1.req_we : port0.req_we);
    assign mem_addr  = !mem_en ? '0 :
                       sel ? port1.req_addr[ADDR_W+1:2] : port0.req_addr[ADDR_W+1:2];
    assign mem_wdata = !mem_en ? '0 : (sel ? port1.req_wdata : port0.req_wdata);

    // Byte offset and bits above the RAM depth are dropped, so addresses alias.
    assign unused_addr_bits = ^{port0.req_addr[31:ADDR_W+2], port0.req_addr[1:0],
                                port1.req_addr[31:ADDR_W+2], port1.req_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_pend <= 1'b0;
            rsp_sel  <= 1'b0;
            rsp_wr   <= 1'b0;
        end else begin
            rsp_pend <= accept;
            rsp_sel  <= accept & sel;
            rsp_wr   <= accept & mem_we;
        end
    end

    // Write responses carry zero data; the strobe alone retires the store.
    assign port0.resp_valid = rsp_pend & (rsp_sel == PORT_IF);
    assign port1.resp_valid = rsp_pend & (rsp_sel == PORT_LS);
    assign port0.resp_rdata = (port0.resp_valid && !rsp_wr) ? mem_rdata : '0;
    assign port1.resp_rdata = (port1.resp_valid && !rsp_wr) ? mem_rdata : '0;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - scoreboard bench for rv32i_mem_arbiter
module tb_rv32i_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    exp_t              sb[$];
    logic              m_last = 1'b1;
    int                errors = 0;
    int                checks = 0;

    rv32i_mem_arbiter_if #(.DATA_W(DATA_W)) p0 ();
    rv32i_mem_arbiter_if #(.DATA_W(DATA_W)) p1 ();

    rv32i_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .port0     (p0.slave),
        .port1     (p1.slave),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Monitor: checks responses against the scoreboard and grants against a model.
    always @(negedge clk) begin
        logic g0, g1, port;
        logic [ADDR_W-1:0] w;
        exp_t e;
        if (reset) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            checks++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port == 1'b0) begin
                    if (p0.resp_valid !== 1'b1 || p0.resp_rdata !== e.data || p1.resp_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL resp0 t=%0t valid=%b rdata=%h other_valid=%b, expected valid=1 rdata=%h other_valid=0",
                                 $time, p0.resp_valid, p0.resp_rdata, p1.resp_valid, e.data);
                    end
                end else begin
                    if (p1.resp_valid !== 1'b1 || p1.resp_rdata !== e.data || p0.resp_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL resp1 t=%0t valid=%b rdata=%h other_valid=%b, expected valid=1 rdata=%h other_valid=0",
                                 $time, p1.resp_valid, p1.resp_rdata, p0.resp_valid, e.data);
                    end
                end
            end else if (p0.resp_valid !== 1'b0 || p1.resp_valid !== 1'b0 ||
                         p0.resp_rdata !== '0 || p1.resp_rdata !== '0) begin
                errors++;
                $display("FAIL resp_idle t=%0t valid=%b%b rdata0=%h rdata1=%h, expected all zero",
                         $time, p1.resp_valid, p0.resp_valid, p0.resp_rdata, p1.resp_rdata);
            end

            g0 = p0.req_valid && (!p1.req_valid || m_last == 1'b1);
            g1 = p1.req_valid && (!p0.req_valid || m_last == 1'b0);
            checks++;
            if (p0.req_ready !== g0 || p1.req_ready !== g1 || mem_en !== (g0 | g1)) begin
                errors++;
                $display("FAIL grant t=%0t ready=%b%b mem_en=%b, expected ready=%b%b mem_en=%b",
                         $time, p1.req_ready, p0.req_ready, mem_en, g1, g0, g0 | g1);
            end
            if (g0 || g1) begin
                port = g1;
                w = g1 ? p1.req_addr[ADDR_W+1:2] : p0.req_addr[ADDR_W+1:2];
                if (g1 ? p1.req_we : p0.req_we) begin
                    sb.push_back('{port: port, data: 32'h0});
                    shadow[w] = g1 ? p1.req_wdata : p0.req_wdata;
                end else begin
                    sb.push_back('{port: port, data: shadow[w]});
                end
                m_last = port;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        p0.req_valid = 1'b0; p0.req_addr = '0; p0.req_we = 1'b0; p0.req_wdata = '0;
        p1.req_valid = 1'b0; p1.req_addr = '0; p1.req_we = 1'b0; p1.req_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        p0.req_valid = 1'b1;
        #1;
        checks++;
        if (p0.req_ready !== 1'b0 || mem_en !== 1'b0 || p0.resp_valid !== 1'b0 || p1.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ready0=%b mem_en=%b resp_valid=%b%b, expected all 0",
                     p0.req_ready, mem_en, p1.resp_valid, p0.resp_valid);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_first_read();
        p0.req_addr = 32'h0;
        #1;
        checks++;
        if (p0.req_ready !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL first_read_req ready0=%b mem_addr=%h mem_we=%b, expected 1 00 0", p0.req_ready, mem_addr, mem_we);
        end
        step();
        p0.req_valid = 1'b0;
        #1;
        checks++;
        if (p0.resp_valid !== 1'b1 || p0.resp_rdata !== 32'h00500093 || p1.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_read_resp valid0=%b rdata0=%h valid1=%b, expected 1 00500093 0",
                     p0.resp_valid, p0.resp_rdata, p1.resp_valid);
        end
        step();
    endtask

    task automatic test_alternation();
        do_reset();
        p0.req_valid = 1'b1; p0.req_addr = 32'h4;
        p1.req_valid = 1'b1; p1.req_addr = 32'h8;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({p1.req_ready, p0.req_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL alternation cycle=%0d ready=%b%b, expected %s", i, p1.req_ready, p0.req_ready,
                         (i % 2 == 0) ? "01" : "10");
            end
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_write_then_read();
        p1.req_valid = 1'b1; p1.req_we = 1'b1; p1.req_addr = 32'h10; p1.req_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (p1.req_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h04 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_req ready1=%b mem_we=%b mem_addr=%h mem_wdata=%h, expected 1 1 04 deadbeef",
                     p1.req_ready, mem_we, mem_addr, mem_wdata);
        end
        step();
        idle_all();
        p0.req_valid = 1'b1; p0.req_addr = 32'h10;
        #1;
        checks++;
        if (p1.resp_valid !== 1'b1 || p1.resp_rdata !== 32'h0 || p0.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ack valid1=%b rdata1=%h ready0=%b, expected 1 00000000 1",
                     p1.resp_valid, p1.resp_rdata, p0.req_ready);
        end
        step();
        idle_all();
        #1;
        checks++;
        if (p0.resp_valid !== 1'b1 || p0.resp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL raw_read valid0=%b rdata0=%h, expected 1 deadbeef", p0.resp_valid, p0.resp_rdata);
        end
        step();
    endtask

    task automatic test_alias();
        p1.req_valid = 1'b1; p1.req_addr = 32'h0000_0404;
        #1;
        checks++;
        if (mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL alias_upper mem_addr=%h, expected 01", mem_addr);
        end
        step();
        p1.req_addr = 32'h0000_0007;
        #1;
        checks++;
        if (mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL alias_low_bits mem_addr=%h, expected 01", mem_addr);
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_reset_mid_op();
        p0.req_valid = 1'b1; p0.req_addr = 32'h8;
        step();
        reset = 1'b1;
        idle_all();
        #1;
        checks++;
        if (p0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard valid0=%b, expected 0", p0.resp_valid);
        end
        step();
        reset = 1'b0;
        p0.req_valid = 1'b1; p0.req_addr = 32'h4;
        p1.req_valid = 1'b1; p1.req_addr = 32'h8;
        #1;
        checks++;
        if (p0.req_ready !== 1'b1 || p1.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pointer ready=%b%b, expected 01", p1.req_ready, p0.req_ready);
        end
        step();
        idle_all();
        step();
    endtask

    task automatic test_idle_then_port1();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
                errors++;
                $display("FAIL idle_mem cycle=%0d mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h, expected all 0",
                         i, mem_en, mem_we, mem_addr, mem_wdata);
            end
            step();
        end
        p1.req_valid = 1'b1; p1.req_addr = 32'hC;
        #1;
        checks++;
        if (p1.req_ready !== 1'b1 || mem_addr !== 8'h03) begin
            errors++;
            $display("FAIL port1_only ready1=%b mem_addr=%h, expected 1 03", p1.req_ready, mem_addr);
        end
        step();
        p0.req_valid = 1'b1; p0.req_addr = 32'h4;
        p1.req_addr = 32'h8;
        #1;
        checks++;
        if (p0.req_ready !== 1'b1 || p1.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL pointer_after_port1 ready=%b%b, expected 01", p1.req_ready, p0.req_ready);
        end
        step();
        idle_all();
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]    = 32'h1357_0000 + i * 32'h0001_0203;
            shadow[i] = 32'h1357_0000 + i * 32'h0001_0203;
        end
        ram[0]    = 32'h00500093;
        shadow[0] = 32'h00500093;
        idle_all();
        step();
        test_reset();
        test_first_read();
        test_alternation();
        test_write_then_read();
        test_alias();
        test_reset_mid_op();
        test_idle_then_port1();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
